mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//   Memory-mapped UART transmitter that consumes the RISC_V core's data-memory store port.
//   - Stores to TXDATA push a byte into a FIFO.
//   - Loads from STATUS return the FIFO and link state.
//   - An FSM serialises each byte as an 8N1 frame on tx, LSB first.
//   Sits beside data memory and decodes its own address window.
// PARAMETERS
//   BASE_ADDR   32'h0000_0100  TXDATA at BASE_ADDR, STATUS at BASE_ADDR+4
//   CLK_DIV     16             clk cycles per serial bit; must be >= 2
//   FIFO_DEPTH  8              byte entries; power of 2, >= 2
// PORTS
//   clk        in   1   single clock; all state updates on rising edge
//   rst        in   1   synchronous, active-high reset
//   we         in   1   core store strobe (same cycle as addr/wdata)
//   addr       in   32  core data address
//   wdata      in   32  core store data; [7:0] = byte for TXDATA
//   rdata      out  32  STATUS read data, combinational; 0 when addr != BASE_ADDR+4
//   tx         out  1   serial line, idle high
//   busy       out  1   (state != IDLE) || FIFO non-empty
//   fifo_full  out  1   FIFO holds FIFO_DEPTH entries
// BEHAVIOUR
//   Reset: tx=1, busy=0, fifo_full=0, overflow=0, FIFO empty, state=IDLE, bit/baud counters 0.
//     rst mid-frame aborts the frame; tx=1 from the next cycle; queued bytes discarded.
//   Push: we && addr==BASE_ADDR.
//     - Not full: wdata[7:0] written at the edge.
//     - Full (after same-edge pop is accounted for): byte dropped, sticky overflow=1.
//   STATUS read: rdata = {29'b0, overflow, fifo_full, busy}.
//   STATUS write (we && addr==BASE_ADDR+4):
//     - wdata[2]=1 clears overflow.
//     - Set wins over clear in the same cycle.
//   Simultaneous push+pop:
//     - When full: accepted, count unchanged.
//     - When empty: no pop can occur, because a pop needs a non-empty FIFO before the edge.
//   FSM: IDLE -> START -> DATA(x8) -> [PARITY] -> STOP -> IDLE/START.
//     - IDLE with FIFO non-empty: pop into shift reg at the edge, go to START.
//     - START drives tx=0. DATA drives shift[0], LSB first, shifts right per bit.
//       STOP drives tx=1.
//     - Each bit lasts exactly CLK_DIV cycles.
//       Baud counter width $clog2(CLK_DIV), wraps to 0 at CLK_DIV-1.
//     - End of STOP with FIFO non-empty: pop and enter START directly (zero idle gap).
//       Otherwise go to IDLE.
//   Latency: push at edge E -> pop at edge E+1 -> tx=0 visible after E+1.
//   Frame = 10*CLK_DIV cycles (11*CLK_DIV with parity).
//   tx is registered (no glitches).
//   Unmatched addresses: no effect, rdata=0.
// CONFIGURATION
//   UART_PARITY_EN defined:
//     - PARITY state between DATA and STOP, lasting CLK_DIV cycles.
//     - Drives even parity (^byte).
//   UART_PARITY_EN undefined: no PARITY state, 8N1 frame. Register map is identical.
// TESTING (CLK_DIV=4, FIFO_DEPTH=8 unless noted)
//   1. rst=1 for 2 cycles -> tx=1, busy=0, fifo_full=0, rdata@STATUS=0.
//   2. Store 0x55 to TXDATA -> tx after E+1: 0,1,0,1,0,1,0,1,0,1, each held 4 cycles.
//      busy=0 exactly 40 cycles after the pop.
//   3. Stores 0x00..0x09 to TXDATA on 10 consecutive cycles -> fifo_full=1 after 9th;
//      10th dropped, overflow=1; exactly bytes 0x00..0x08 sent back-to-back, no idle gap.
//   4. After 3, store 0x4 to STATUS -> overflow=0, rdata[2]=0 next cycle; other bits unaffected.
//   5. Assert rst at cycle 15 of a frame with 3 bytes queued -> tx=1 next cycle, busy=0,
//      nothing more sent.
//   6. With UART_PARITY_EN: store 0x07 -> parity bit 1, frame 44 cycles.
//      Store 0x03 -> parity bit 0.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA stores feed a byte FIFO drained as 8N1 frames on tx.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy,
  output logic        fifo_full
);

  localparam int              BW          = $clog2(CLK_DIV);
  localparam int              AW          = $clog2(FIFO_DEPTH);
  localparam logic [31:0]     STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [BW-1:0]   BAUD_LAST   = BW'(CLK_DIV - 1);
  localparam logic [AW:0]     FULL_COUNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_next;
  logic [BW-1:0]   baud, baud_next;
  logic [2:0]      bitcnt, bitcnt_next;
  logic [7:0]      shift, shift_next;
  logic            tx_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic            overflow;
  logic            baud_last, fifo_empty, push_hit, status_hit;
  logic            pop, push_ok, push_drop;
  logic            unused_wdata;

  assign unused_wdata = ^{wdata[31:8], wdata[6:3]};

  assign baud_last  = (baud == BAUD_LAST);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);
  assign push_hit   = we && (addr == BASE_ADDR);
  assign status_hit = we && (addr == STATUS_ADDR);
  // A pop only happens at a frame boundary, so a full FIFO can still accept a same-edge push.
  assign pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_last));
  assign push_ok    = push_hit && (!fifo_full || pop);
  assign push_drop  = push_hit && !push_ok;

  assign busy  = (state != IDLE) || !fifo_empty;
  assign rdata = (addr == STATUS_ADDR) ? {29'b0, overflow, fifo_full, busy} : 32'b0;

`ifdef UART_PARITY_EN
  logic parbit, parbit_next;
  assign parbit_next = pop ? ^mem[rptr] : parbit;
`endif

  always_comb begin
    state_next  = state;
    baud_next   = baud;
    bitcnt_next = bitcnt;
    shift_next  = shift;
    if (state != IDLE) baud_next = baud_last ? '0 : baud + 1'b1;
    case (state)
      IDLE: begin
        if (pop) begin
          state_next = START;
          shift_next = mem[rptr];
        end
      end
      START: if (baud_last) state_next = DATA;
      DATA: begin
        if (baud_last) begin
          shift_next = {1'b0, shift[7:1]};
          if (bitcnt == 3'd7) begin
            bitcnt_next = '0;
`ifdef UART_PARITY_EN
            state_next  = PARITY;
`else
            state_next  = STOP;
`endif
          end else begin
            bitcnt_next = bitcnt + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: if (baud_last) state_next = STOP;
`endif
      STOP: begin
        if (baud_last) begin
          if (pop) begin
            state_next = START;
            shift_next = mem[rptr];
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line level is derived from the upcoming state so tx comes straight from a flop.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_PARITY_EN
      PARITY:  tx_next = parbit;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud     <= '0;
      bitcnt   <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state  <= state_next;
      baud   <= baud_next;
      bitcnt <= bitcnt_next;
      shift  <= shift_next;
      tx     <= tx_next;
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_drop)                 overflow <= 1'b1;
      else if (status_hit && wdata[2]) overflow <= 1'b0;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parbit <= 1'b0;
    else     parbit <= parbit_next;
  end
`endif

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata[7:0];
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLK_DIV=4, FIFO_DEPTH=8.
// Build with UART_PARITY_EN to cover the parity frame variant.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam logic [31:0] STATUS = 32'h0000_0104;
  localparam int          DIV    = 4;
`ifdef UART_PARITY_EN
  localparam int          FBITS  = 11;
`else
  localparam int          FBITS  = 10;
`endif
  localparam int          FCYC   = FBITS * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx, busy, fifo_full;
  int          checks = 0;
  int          errors = 0;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .tx(tx), .busy(busy), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  // Expected line level for bit slot p of a frame carrying byte b.
  function automatic logic frameBit(input logic [7:0] b, input int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
`ifdef UART_PARITY_EN
    if (p == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    rst   = r;
    we    = w;
    addr  = a;
    wdata = d;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Push one byte from idle and follow its whole frame cycle by cycle.
  task automatic sendAndCheck(input logic [7:0] b);
    applyStimulus(1'b0, 1'b1, BASE, {24'b0, b});
    tick();
    applyStimulus(1'b0, 1'b0, STATUS, 32'b0);
    checkOutput("push_busy", {31'b0, busy}, 32'd1);
    checkOutput("push_tx_idle", {31'b0, tx}, 32'd1);
    tick();
    for (int i = 0; i < FCYC; i++) begin
      checkOutput($sformatf("frame_%0h_c%0d", b, i), {31'b0, tx}, {31'b0, frameBit(b, i / DIV)});
      checkOutput("frame_busy", {31'b0, busy}, 32'd1);
      tick();
    end
    checkOutput("frame_end_busy", {31'b0, busy}, 32'd0);
    checkOutput("frame_end_tx", {31'b0, tx}, 32'd1);
  endtask

  initial begin
    // Reset state.
    applyStimulus(1'b1, 1'b0, STATUS, 32'b0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, STATUS, 32'b0);
    checkOutput("rst_tx", {31'b0, tx}, 32'd1);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_full", {31'b0, fifo_full}, 32'd0);
    checkOutput("rst_status", rdata, 32'd0);

    // Single bytes.
    sendAndCheck(8'h55);
    sendAndCheck(8'hA3);

    // Ten back-to-back stores: nine fit, the tenth overflows.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b1, BASE, k);
      tick();
      if (k >= 1)
        checkOutput($sformatf("burst_c%0d", k - 1), {31'b0, tx}, {31'b0, frameBit(8'h00, (k - 1) / DIV)});
      if (k == 7) checkOutput("full_after_8th", {31'b0, fifo_full}, 32'd0);
      if (k == 8) checkOutput("full_after_9th", {31'b0, fifo_full}, 32'd1);
    end
    applyStimulus(1'b0, 1'b0, STATUS, 32'b0);
    checkOutput("overflow_status", rdata, 32'd7);
    for (int idx = 9; idx < 9 * FCYC; idx++) begin
      tick();
      checkOutput($sformatf("stream_c%0d", idx), {31'b0, tx},
                  {31'b0, frameBit(8'(idx / FCYC), (idx % FCYC) / DIV)});
    end
    tick();
    checkOutput("stream_done_busy", {31'b0, busy}, 32'd0);
    checkOutput("stream_done_status", rdata, 32'd4);

    // Clear the sticky overflow flag.
    applyStimulus(1'b0, 1'b1, STATUS, 32'd4);
    tick();
    applyStimulus(1'b0, 1'b0, STATUS, 32'b0);
    checkOutput("overflow_cleared", rdata, 32'd0);

    // Unmatched address has no effect.
    applyStimulus(1'b0, 1'b1, BASE + 32'd8, 32'hAA);
    checkOutput("unmatched_rdata", rdata, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, STATUS, 32'b0);
    checkOutput("unmatched_busy", {31'b0, busy}, 32'd0);
    tick();
    checkOutput("unmatched_tx", {31'b0, tx}, 32'd1);

    // Reset mid-frame with three bytes still queued.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, BASE, 32'h00);
      tick();
    end
    applyStimulus(1'b0, 1'b0, STATUS, 32'b0);
    checkOutput("queued_status", rdata, 32'd1);
    repeat (13) tick();
    checkOutput("midframe_tx", {31'b0, tx}, 32'd0);
    applyStimulus(1'b1, 1'b0, STATUS, 32'b0);
    tick();
    checkOutput("abort_tx", {31'b0, tx}, 32'd1);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_full", {31'b0, fifo_full}, 32'd0);
    applyStimulus(1'b0, 1'b0, STATUS, 32'b0);
    for (int i = 0; i < 60; i++) begin
      tick();
      checkOutput($sformatf("after_abort_c%0d", i), {30'b0, busy, tx}, 32'd1);
    end

`ifdef UART_PARITY_EN
    // Parity bit is 1 for 0x07 and 0 for 0x03.
    sendAndCheck(8'h07);
    sendAndCheck(8'h03);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
